// File: rtl/mem_access_pkg.sv
// mem_access_pkg: memory op codes, stage states and op classification helpers.
package mem_access_pkg;

    localparam int MEM_OP_BUS = 4;

    localparam logic [MEM_OP_BUS-1:0] MEM_NOP = 4'd0;
    localparam logic [MEM_OP_BUS-1:0] LB      = 4'd1;
    localparam logic [MEM_OP_BUS-1:0] LBU     = 4'd2;
    localparam logic [MEM_OP_BUS-1:0] LH      = 4'd3;
    localparam logic [MEM_OP_BUS-1:0] LHU     = 4'd4;
    localparam logic [MEM_OP_BUS-1:0] LW      = 4'd5;
    localparam logic [MEM_OP_BUS-1:0] SB      = 4'd6;
    localparam logic [MEM_OP_BUS-1:0] SH      = 4'd7;
    localparam logic [MEM_OP_BUS-1:0] SW      = 4'd8;

    typedef enum logic {IDLE, BUS} state_e;

    function automatic logic is_load(input logic [MEM_OP_BUS-1:0] op);
        return op inside {LB, LBU, LH, LHU, LW};
    endfunction

    function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
        return op inside {SB, SH, SW};
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_access_align: byte-lane select, store replication, load extraction and
// alignment check for one little-endian 32-bit access.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [MEM_OP_BUS-1:0] op,
    input  logic [1:0]            addr_lo,
    input  logic [31:0]           sdata,
    input  logic [31:0]           rdata,
    output logic                  misalign,
    output logic [3:0]            sel,
    output logic [31:0]           wdata,
    output logic [31:0]           ldata
);

    logic        is_b, is_h, is_w;
    logic [31:0] shifted;
    logic [15:0] half;

    always_comb begin
        is_b     = op inside {LB, LBU, SB};
        is_h     = op inside {LH, LHU, SH};
        is_w     = op inside {LW, SW};
        misalign = (is_h & addr_lo[0]) | (is_w & (|addr_lo));
        sel      = is_b ? (4'b0001 << addr_lo) :
                   is_h ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                   is_w ? 4'b1111 : 4'b0000;
        wdata    = is_b ? {4{sdata[7:0]}} : is_h ? {2{sdata[15:0]}} : sdata;
        shifted  = rdata >> {addr_lo, 3'b000};
        half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ldata    = (op == LB)  ? {{24{shifted[7]}}, shifted[7:0]} :
                   (op == LBU) ? {24'd0, shifted[7:0]} :
                   (op == LH)  ? {{16{half[15]}}, half} :
                   (op == LHU) ? {16'd0, half} :
                   (op == LW)  ? rdata : 32'd0;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage; registers the execute result and runs one
// req/ack data-bus transaction per load/store, stalling upstream meanwhile.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [MEM_OP_BUS-1:0] mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_data_i,
    input  logic                  flush_i,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stall_req_o,
    output logic                  misalign_o,
    output logic [ADDR_W-1:0]     badaddr_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i
);

    state_e                state, next_state;
    logic [MEM_OP_BUS-1:0] op_q, align_op;
    logic [1:0]            alo_q, align_lo;
    logic [4:0]            wd_q;
    logic                  wreg_q, flushed_q;
    logic                  pass, accept, go_bus, mis;
    logic                  al_misalign;
    logic [3:0]            al_sel;
    logic [31:0]           al_wdata, al_ldata;

    // One aligner serves both phases: request fields in IDLE, load extraction in BUS.
    mem_align u_align (
        .op       (align_op),
        .addr_lo  (align_lo),
        .sdata    (mem_data_i),
        .rdata    (bus_rdata_i),
        .misalign (al_misalign),
        .sel      (al_sel),
        .wdata    (al_wdata),
        .ldata    (al_ldata)
    );

    always_comb begin
        align_op    = (state == BUS) ? op_q : mem_op_i;
        align_lo    = (state == BUS) ? alo_q : mem_addr_i[1:0];
        pass        = valid_i & !flush_i & !(is_load(mem_op_i) | is_store(mem_op_i));
        accept      = (state == IDLE) & valid_i & !flush_i & (is_load(mem_op_i) | is_store(mem_op_i));
        go_bus      = accept & !al_misalign;
        mis         = accept & al_misalign;
        stall_req_o = go_bus | ((state == BUS) & !bus_ack_i);
        next_state  = state;
        if (state == IDLE && go_bus)
            next_state = BUS;
        else if (state == BUS && bus_ack_i)
            next_state = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= MEM_NOP;
            alo_q       <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            flushed_q   <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
            misalign_o  <= 1'b0;
            badaddr_o   <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
        end else begin
            state      <= next_state;
            misalign_o <= mis;
            if (mis)
                badaddr_o <= mem_addr_i;
            if (state == IDLE) begin
                wd_o      <= pass ? wd_i : '0;
                wreg_o    <= pass & wreg_i;
                wdata_o   <= pass ? wdata_i : '0;
                flushed_q <= 1'b0;
                if (go_bus) begin
                    op_q        <= mem_op_i;
                    alo_q       <= mem_addr_i[1:0];
                    wd_q        <= wd_i;
                    wreg_q      <= wreg_i;
                    bus_req_o   <= 1'b1;
                    bus_we_o    <= is_store(mem_op_i);
                    bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                    bus_sel_o   <= al_sel;
                    bus_wdata_o <= al_wdata;
                end
            end else if (bus_ack_i) begin
                wd_o        <= wd_q;
                wreg_o      <= wreg_q & !flushed_q & !flush_i;
                wdata_o     <= is_load(op_q) ? al_ldata : '0;
                bus_req_o   <= 1'b0;
                bus_we_o    <= 1'b0;
                bus_addr_o  <= '0;
                bus_sel_o   <= '0;
                bus_wdata_o <= '0;
            end else begin
                flushed_q <= flushed_q | flush_i;
                wd_o      <= '0;
                wreg_o    <= 1'b0;
                wdata_o   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for the mem_access stage.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_i = 1'b0, wreg_i = 1'b0, flush_i = 1'b0, bus_ack_i = 1'b0;
    logic [4:0]  wd_i = '0;
    logic [31:0] wdata_i = '0, mem_addr_i = '0, mem_data_i = '0, bus_rdata_i = '0;
    logic [3:0]  mem_op_i = MEM_NOP;
    logic [4:0]  wd_o;
    logic        wreg_o, stall_req_o, misalign_o, bus_req_o, bus_we_o;
    logic [31:0] wdata_o, badaddr_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } res_t;

    res_t q[$];
    int   errors = 0;
    int   checks = 0;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stall_req_o(stall_req_o), .misalign_o(misalign_o),
        .badaddr_o(badaddr_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        valid_i    = 1'b1;
        mem_op_i   = op;
        mem_addr_i = addr;
        mem_data_i = sdata;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = wdata;
    endtask

    task automatic idle_in();
        valid_i  = 1'b0;
        mem_op_i = MEM_NOP;
        wreg_i   = 1'b0;
    endtask

    task automatic push(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        res_t r;
        r.wd    = wd;
        r.wreg  = wreg;
        r.wdata = wdata;
        q.push_back(r);
    endtask

    task automatic pop_check(input string tag);
        res_t r;
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
        end
        if (q.size() != 0) begin
            r = q.pop_front();
            check({tag, ".wd"}, {27'd0, wd_o}, {27'd0, r.wd});
            check({tag, ".wreg"}, {31'd0, wreg_o}, {31'd0, r.wreg});
            check({tag, ".wdata"}, wdata_o, r.wdata);
        end
    endtask

    initial begin
        step();
        step();
        check("rst.wreg", {31'd0, wreg_o}, 32'd0);
        check("rst.wdata", wdata_o, 32'd0);
        check("rst.bus_req", {31'd0, bus_req_o}, 32'd0);
        check("rst.badaddr", badaddr_o, 32'd0);
        rst = 1'b0;
        step();

        issue(MEM_NOP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234);
        push(5'd3, 1'b1, 32'h1234);
        #1 check("nop.stall", {31'd0, stall_req_o}, 32'd0);
        step();
        idle_in();
        pop_check("nop");

        issue(LB, 32'h103, 32'h0, 5'd5, 1'b1, 32'h0);
        push(5'd5, 1'b1, 32'hFFFF_FF80);
        #1 check("lb.stall_accept", {31'd0, stall_req_o}, 32'd1);
        step();
        idle_in();
        bus_rdata_i = 32'h80FF_FF00;
        for (int i = 0; i < 2; i++) begin
            check("lb.req", {31'd0, bus_req_o}, 32'd1);
            check("lb.addr", bus_addr_o, 32'h100);
            check("lb.sel", {28'd0, bus_sel_o}, 32'h8);
            check("lb.stall_wait", {31'd0, stall_req_o}, 32'd1);
            step();
        end
        bus_ack_i = 1'b1;
        #1 check("lb.stall_ack", {31'd0, stall_req_o}, 32'd0);
        step();
        bus_ack_i = 1'b0;
        pop_check("lb");
        check("lb.req_drop", {31'd0, bus_req_o}, 32'd0);

        issue(LHU, 32'h202, 32'h0, 5'd7, 1'b1, 32'h0);
        push(5'd7, 1'b1, 32'h0000_ABCD);
        step();
        idle_in();
        check("lhu.sel", {28'd0, bus_sel_o}, 32'hC);
        bus_rdata_i = 32'hABCD_0000;
        bus_ack_i   = 1'b1;
        step();
        bus_ack_i = 1'b0;
        pop_check("lhu");

        issue(SB, 32'h001, 32'h5A, 5'd0, 1'b0, 32'h0);
        push(5'd0, 1'b0, 32'h0);
        step();
        idle_in();
        check("sb.we", {31'd0, bus_we_o}, 32'd1);
        check("sb.sel", {28'd0, bus_sel_o}, 32'h2);
        check("sb.wdata", bus_wdata_o, 32'h5A5A_5A5A);
        check("sb.addr", bus_addr_o, 32'h0);
        bus_ack_i = 1'b1;
        step();
        bus_ack_i = 1'b0;
        pop_check("sb");

        issue(LW, 32'h006, 32'h0, 5'd4, 1'b1, 32'h0);
        #1 check("mis.stall", {31'd0, stall_req_o}, 32'd0);
        step();
        idle_in();
        check("mis.flag", {31'd0, misalign_o}, 32'd1);
        check("mis.badaddr", badaddr_o, 32'h006);
        check("mis.req", {31'd0, bus_req_o}, 32'd0);
        check("mis.wreg", {31'd0, wreg_o}, 32'd0);
        step();
        check("mis.pulse_end", {31'd0, misalign_o}, 32'd0);
        check("mis.badaddr_hold", badaddr_o, 32'h006);

        issue(LW, 32'h010, 32'h0, 5'd9, 1'b1, 32'h0);
        push(5'd9, 1'b0, 32'hCAFE_F00D);
        step();
        idle_in();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush.req_held", {31'd0, bus_req_o}, 32'd1);
        check("flush.addr", bus_addr_o, 32'h010);
        bus_rdata_i = 32'hCAFE_F00D;
        bus_ack_i   = 1'b1;
        step();
        bus_ack_i = 1'b0;
        pop_check("flush");

        bus_ack_i = 1'b1;
        step();
        bus_ack_i = 1'b0;
        check("idle_ack.req", {31'd0, bus_req_o}, 32'd0);
        check("idle_ack.wreg", {31'd0, wreg_o}, 32'd0);

        issue(MEM_NOP, 32'h0, 32'h0, 5'd11, 1'b1, 32'h77);
        flush_i = 1'b1;
        push(5'd0, 1'b0, 32'h0);
        step();
        flush_i = 1'b0;
        idle_in();
        pop_check("flush_nop");

        issue(LW, 32'h020, 32'h0, 5'd2, 1'b1, 32'h0);
        step();
        idle_in();
        check("rstbus.req", {31'd0, bus_req_o}, 32'd1);
        rst = 1'b1;
        #1 check("rstbus.req_async", {31'd0, bus_req_o}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("rstbus.stall", {31'd0, stall_req_o}, 32'd0);
        issue(MEM_NOP, 32'h0, 32'h0, 5'd6, 1'b1, 32'hBEEF);
        push(5'd6, 1'b1, 32'hBEEF);
        step();
        idle_in();
        pop_check("rstbus.idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
